// File: rtl/fnd_decimal_display.sv
// Signed binary to multiplexed seven-segment decimal display: a sequential double-dabble
// converter feeds an atomically committed digit buffer that is scanned continuously.
module fnd_decimal_display #(
  parameter int WIDTH    = 32,
  parameter int DIGITS   = 6,
  parameter int SCAN_DIV = 1
) (
  input  logic              fnd_clk,
  input  logic              rst,
  input  logic              load,
  input  logic [WIDTH-1:0]  value,
  output logic              busy,
  output logic [DIGITS-1:0] fnd_s,
  output logic [7:0]        fnd_d
);

  localparam int BCD_DIG = (WIDTH * 301) / 1000 + 1;
  localparam int BCD_W   = 4 * BCD_DIG;
  localparam int MAXN    = (BCD_DIG > DIGITS + 1) ? BCD_DIG : DIGITS + 1;
  localparam int SC_W    = $clog2(WIDTH + 1);
  localparam int IDX_W   = $clog2(DIGITS);
  localparam int CNT_W   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  typedef enum logic [1:0] {S_IDLE, S_ABS, S_SHIFT, S_COMMIT} state_e;

  function automatic logic [7:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 8'h3F;
      4'd1:    seg7 = 8'h06;
      4'd2:    seg7 = 8'h5B;
      4'd3:    seg7 = 8'h4F;
      4'd4:    seg7 = 8'h66;
      4'd5:    seg7 = 8'h6D;
      4'd6:    seg7 = 8'h7D;
      4'd7:    seg7 = 8'h07;
      4'd8:    seg7 = 8'h7F;
      4'd9:    seg7 = 8'h6F;
      default: seg7 = 8'h00;
    endcase
  endfunction

  state_e             state_q, state_d;
  logic               busy_q, busy_d;
  logic [WIDTH-1:0]   val_q, val_d;
  logic               sign_q, sign_d;
  logic [WIDTH-1:0]   mag_q, mag_d;
  logic [BCD_W-1:0]   bcd_q, bcd_d;
  logic [SC_W-1:0]    sc_q, sc_d;
  logic [7:0]         disp_q [DIGITS];
  logic [7:0]         disp_d [DIGITS];
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [DIGITS-1:0]  fnd_s_q, fnd_s_d;
  logic [7:0]         fnd_d_q, fnd_d_d;

  logic [BCD_W-1:0]   bcd_adj;
  logic [4*MAXN-1:0]  bcd_ext;
  logic [7:0]         disp_new [DIGITS];
  logic               ovf;
  int                 msn;

  // Formatting of the finished BCD result; only consumed in COMMIT.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    ovf     = 1'b0;
    msn     = 0;
    bcd_ext = '0;
    bcd_ext[BCD_W-1:0] = bcd_q;
    for (int i = 0; i < BCD_DIG; i++) begin
      if (bcd_q[4*i +: 4] != 4'd0) begin
        msn = i;
        if (i >= DIGITS || (sign_q && i >= DIGITS - 1)) ovf = 1'b1;
      end
    end
    for (int d = 0; d < DIGITS; d++) begin
      disp_new[d] = 8'h00;
      if (ovf) begin
        if (d == 2)      disp_new[d] = 8'h79;
        else if (d < 2)  disp_new[d] = 8'h50;
      end else if (d <= msn) begin
        disp_new[d] = seg7(bcd_ext[4*d +: 4]);
      end else if (sign_q && d == msn + 1) begin
        disp_new[d] = 8'h40;
      end
    end
  end

  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < BCD_DIG; i++)
      if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
  end

  always_comb begin
    state_d = state_q;
    busy_d  = busy_q;
    val_d   = val_q;
    sign_d  = sign_q;
    mag_d   = mag_q;
    bcd_d   = bcd_q;
    sc_d    = sc_q;
    disp_d  = disp_q;
    case (state_q)
      S_IDLE: if (load) begin
        val_d   = value;
        busy_d  = 1'b1;
        state_d = S_ABS;
      end
      S_ABS: begin
        sign_d  = val_q[WIDTH-1];
        mag_d   = val_q[WIDTH-1] ? (~val_q + 1'b1) : val_q;
        bcd_d   = '0;
        sc_d    = '0;
        state_d = S_SHIFT;
      end
      S_SHIFT: begin
        bcd_d = {bcd_adj[BCD_W-2:0], mag_q[WIDTH-1]};
        mag_d = {mag_q[WIDTH-2:0], 1'b0};
        sc_d  = sc_q + 1'b1;
        if (sc_q == SC_W'(WIDTH - 1)) state_d = S_COMMIT;
      end
      S_COMMIT: begin
        disp_d  = disp_new;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Select and segment data are registered from the same idx so they can never disagree.
  always_comb begin
    fnd_s_d = ~(DIGITS'(1) << idx_q);
    fnd_d_d = disp_q[idx_q];
    idx_d   = idx_q;
    cnt_d   = cnt_q + 1'b1;
    if (cnt_q == CNT_W'(SCAN_DIV - 1)) begin
      cnt_d = '0;
      idx_d = (idx_q == IDX_W'(DIGITS - 1)) ? '0 : idx_q + 1'b1;
    end
  end

  always_ff @(posedge fnd_clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      busy_q  <= 1'b0;
      val_q   <= '0;
      sign_q  <= 1'b0;
      mag_q   <= '0;
      bcd_q   <= '0;
      sc_q    <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      fnd_s_q <= '1;
      fnd_d_q <= 8'h00;
      // NOTE: the digit buffer is a handful of flops with a defined power-up image, so it is reset.
      for (int d = 0; d < DIGITS; d++) disp_q[d] <= (d == 0) ? 8'h3F : 8'h00;
    end else begin
      // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
      state_q <= state_d;
      busy_q  <= busy_d;
      val_q   <= val_d;
      sign_q  <= sign_d;
      mag_q   <= mag_d;
      bcd_q   <= bcd_d;
      sc_q    <= sc_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      fnd_s_q <= fnd_s_d;
      fnd_d_q <= fnd_d_d;
      disp_q  <= disp_d;
    end
  end

  assign busy  = busy_q;
  assign fnd_s = fnd_s_q;
  assign fnd_d = fnd_d_q;

endmodule

// File: tb/tb_fnd_decimal_display.sv
// Self-checking bench for fnd_decimal_display: directed vector table, random values against a
// decimal-arithmetic reference model, and hand-written load/reset/scan sequences.
module tb_fnd_decimal_display;

  logic        clk;
  logic        rst_n;
  logic        load;
  logic [31:0] value;
  logic        busy;
  logic [5:0]  fnd_s;
  logic [7:0]  fnd_d;
  logic        busy2;
  logic [3:0]  fnd_s2;
  logic [7:0]  fnd_d2;

  int tests  = 0;
  int failed = 0;

  localparam logic [7:0] SEG [10] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66,
                                      8'h6D, 8'h7D, 8'h07, 8'h7F, 8'h6F};
  localparam logic [47:0] ERR = 48'h000000795050;

  fnd_decimal_display dut (
    .fnd_clk(clk), .rst(rst_n), .load(load), .value(value),
    .busy(busy), .fnd_s(fnd_s), .fnd_d(fnd_d)
  );

  fnd_decimal_display #(.WIDTH(32), .DIGITS(4), .SCAN_DIV(4)) dut2 (
    .fnd_clk(clk), .rst(rst_n), .load(1'b0), .value(32'd0),
    .busy(busy2), .fnd_s(fnd_s2), .fnd_d(fnd_d2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      failed++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  // Reference: decimal digits by repeated division, then the display rules.
  function automatic logic [47:0] model(input longint v);
    logic [47:0] res;
    longint      mag;
    int          dig [12];
    int          n;
    bit          neg;
    neg = (v < 0);
    mag = neg ? -v : v;
    n   = 0;
    do begin
      dig[n] = int'(mag % 10);
      mag    = mag / 10;
      n++;
    end while (mag != 0);
    if ((!neg && n > 6) || (neg && n > 5)) return ERR;
    res = '0;
    for (int i = 0; i < n; i++) res[8*i +: 8] = SEG[dig[i]];
    if (neg) res[8*n +: 8] = 8'h40;
    return res;
  endfunction

  task automatic read_display(output logic [47:0] got);
    got = '1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      for (int i = 0; i < 6; i++)
        if (fnd_s == ~(6'd1 << i)) got[8*i +: 8] = fnd_d;
    end
  endtask

  task automatic convert(input logic [31:0] v, output int cycles);
    @(negedge clk);
    load  = 1'b1;
    value = v;
    @(negedge clk);
    load   = 1'b0;
    cycles = 0;
    while (busy && cycles < 200) begin
      cycles++;
      @(negedge clk);
    end
  endtask

  typedef struct {
    logic [31:0] v;
    logic [47:0] exp;
    string       name;
  } vec_t;

  vec_t vecs [12];

  initial begin
    logic [47:0] got;
    int          cycles;
    bit          ok;
    longint      rv;

    vecs[0]  = '{32'd123,          48'h000000065B4F, "pos_123"};
    vecs[1]  = '{-32'sd12345,      48'h40065B4F666D, "neg_12345"};
    vecs[2]  = '{-32'sd7,          48'h000000004007, "neg_7"};
    vecs[3]  = '{32'd999999,       48'h6F6F6F6F6F6F, "max_pos"};
    vecs[4]  = '{32'd1000000,      ERR,              "ovf_pos"};
    vecs[5]  = '{-32'sd99999,      48'h406F6F6F6F6F, "max_neg"};
    vecs[6]  = '{-32'sd123456,     ERR,              "ovf_neg"};
    vecs[7]  = '{32'h80000000,     ERR,              "int_min"};
    vecs[8]  = '{32'd0,            48'h00000000003F, "zero"};
    vecs[9]  = '{32'h7FFFFFFF,     ERR,              "int_max"};
    vecs[10] = '{32'd100000,       48'h063F3F3F3F3F, "pos_100000"};
    vecs[11] = '{-32'sd100000,     ERR,              "neg_100000"};

    rst_n = 1'b0;
    load  = 1'b0;
    value = '0;
    repeat (3) @(negedge clk);
    check("reset_busy",  64'(busy),  64'd0);
    check("reset_fnd_s", 64'(fnd_s), 64'h3F);
    check("reset_fnd_d", 64'(fnd_d), 64'h00);
    rst_n = 1'b1;

    // First 16 edges after release: small DUT holds each select 4 cycles; big DUT scans '0'.
    got = '1;
    ok  = 1'b1;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      if (k == 0) begin
        check("first_fnd_s", 64'(fnd_s), 64'h3E);
        check("first_fnd_d", 64'(fnd_d), 64'h3F);
      end
      if (k < 6)
        for (int i = 0; i < 6; i++)
          if (fnd_s == ~(6'd1 << i)) got[8*i +: 8] = fnd_d;
      if (fnd_s2 != 4'(~(4'd1 << (k / 4))) || fnd_d2 != ((k / 4 == 0) ? 8'h3F : 8'h00)) ok = 1'b0;
    end
    check("reset_display", 64'(got), 64'h3F);
    check("scan_div4_order", 64'(ok), 64'd1);
    ok = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (fnd_s2 != 4'(~(4'd1 << (k / 4)))) ok = 1'b0;
    end
    check("scan_div4_wrap", 64'(ok), 64'd1);

    foreach (vecs[j]) begin
      convert(vecs[j].v, cycles);
      check({vecs[j].name, "_latency"}, 64'(cycles), 64'd34);
      read_display(got);
      check(vecs[j].name, 64'(got), 64'(vecs[j].exp));
    end

    for (int r = 0; r < 24; r++) begin
      if ($urandom_range(0, 4) == 0) begin
        rv = longint'($signed($urandom));
      end else begin
        rv = longint'($urandom % (32'd10 ** $urandom_range(1, 8)));
        if ($urandom_range(0, 1) == 1) rv = -rv;
      end
      convert(32'(rv), cycles);
      read_display(got);
      check($sformatf("rand_%0d", rv), 64'(got), 64'(model(rv)));
    end

    // A load while busy is dropped: latency stays 34 and the first value is shown.
    @(negedge clk);
    load  = 1'b1;
    value = 32'd111;
    @(negedge clk);
    load   = 1'b0;
    cycles = 0;
    while (busy && cycles < 200) begin
      cycles++;
      if (cycles == 5) begin
        load  = 1'b1;
        value = 32'd999;
      end else begin
        load = 1'b0;
      end
      @(negedge clk);
    end
    load = 1'b0;
    check("drop_latency", 64'(cycles), 64'd34);
    ok = 1'b1;
    repeat (5) begin
      @(negedge clk);
      if (busy) ok = 1'b0;
    end
    check("drop_no_requeue", 64'(ok), 64'd1);
    read_display(got);
    check("drop_display", 64'(got), 64'h000000060606);

    // Reset during conversion aborts it and restores '0'.
    @(negedge clk);
    load  = 1'b1;
    value = 32'd555;
    @(negedge clk);
    load = 1'b0;
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_fnd_s", 64'(fnd_s), 64'h3F);
    @(negedge clk);
    rst_n = 1'b1;
    ok = 1'b1;
    repeat (40) begin
      @(negedge clk);
      if (busy) ok = 1'b0;
    end
    check("abort_no_commit", 64'(ok), 64'd1);
    read_display(got);
    check("abort_display", 64'(got), 64'h3F);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
